// File: rtl/vld_rdy_multi_trace_capture.sv
// Passive multi-channel valid/ready trace recorder.
// Timestamps snooped transfers, buffers per channel, drains round-robin.
module vld_rdy_multi_trace_capture #(
  parameter int NCH   = 4,
  parameter int DATAW = 8,
  parameter int DEPTH = 8,
  parameter int TSW   = 64,
  parameter int DROPW = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NCH-1:0]       mon_valid,
  input  logic [NCH-1:0]       mon_ready,
  input  logic [NCH*DATAW-1:0] mon_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_chan,
  output logic [TSW-1:0]       out_ts,
  output logic [DATAW-1:0]     out_data,
  output logic [NCH-1:0]       ovf,
  output logic [DROPW-1:0]     drop_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [TSW-1:0]   cnt;
  logic [TSW-1:0]   ts_mem [NCH][DEPTH];
  logic [DATAW-1:0] d_mem  [NCH][DEPTH];
  logic [PW:0]      wp [NCH];
  logic [PW:0]      rp [NCH];

  logic [NCH-1:0] empty, full, cap, pop, wr, drop;
  logic [CHW-1:0] rr, grant, pick, sel, nxt;
  logic           hold, found, xfer;
  logic [DROPW:0] dsum;
  int             idx;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i][PW] != rp[i][PW]) &&
                 (wp[i][PW-1:0] == rp[i][PW-1:0]);
    end
  end

  // Scan from the rr pointer for the first channel with data.
  always_comb begin
    pick  = rr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr) + k) % NCH;
      if (!found && !empty[idx]) begin
        pick  = CHW'(idx);
        found = 1'b1;
      end
    end
  end

  assign sel       = hold ? grant : pick;
  assign out_valid = !empty[sel];
  assign xfer      = out_valid && out_ready;
  assign nxt       = (sel == CHW'(NCH - 1)) ? '0 : sel + CHW'(1);

  assign out_chan = out_valid ? sel : '0;
  assign out_ts   = out_valid ? ts_mem[sel][rp[sel][PW-1:0]] : '0;
  assign out_data = out_valid ? d_mem[sel][rp[sel][PW-1:0]] : '0;

  // A full FIFO still accepts when its head leaves on the same edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cap[i]  = en && mon_valid[i] && mon_ready[i];
      pop[i]  = xfer && (sel == CHW'(i));
      wr[i]   = cap[i] && (!full[i] || pop[i]);
      drop[i] = cap[i] && !wr[i];
    end
  end

  always_comb begin
    dsum = {1'b0, drop_cnt};
    for (int i = 0; i < NCH; i++)
      dsum = dsum + {{DROPW{1'b0}}, drop[i]};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr[i]) begin
        ts_mem[i][wp[i][PW-1:0]] <= cnt;
        d_mem[i][wp[i][PW-1:0]]  <= mon_data[i*DATAW +: DATAW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rr    <= '0;
      grant <= '0;
      hold  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      cnt   <= cnt + TSW'(1);
      hold  <= out_valid && !out_ready;
      grant <= sel;
      if (xfer) rr <= nxt;
      for (int i = 0; i < NCH; i++) begin
        if (wr[i])  wp[i] <= wp[i] + 1'b1;
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end else begin
      ovf      <= ovf | drop;
      drop_cnt <= dsum[DROPW] ? '1 : dsum[DROPW-1:0];
    end
  end

endmodule

// File: tb/tb_vld_rdy_multi_trace_capture.sv
// Scoreboard bench for vld_rdy_multi_trace_capture.
// Expected records are queued at capture time and popped on output transfer.
module tb_vld_rdy_multi_trace_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  mon_valid = '0;
  logic [3:0]  mon_ready = '0;
  logic [31:0] mon_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_chan;
  logic [63:0] out_ts;
  logic [7:0]  out_data;
  logic [3:0]  ovf;
  logic [15:0] drop_cnt;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] ts;
    logic [7:0]  d;
  } rec_t;

  rec_t        q[$];
  rec_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] ecnt;

  vld_rdy_multi_trace_capture dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_data(mon_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan),
    .out_ts(out_ts), .out_data(out_data),
    .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) ecnt <= '0;
    else      ecnt <= ecnt + 64'd1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_rec", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("rec_chan", 64'(out_chan), 64'(e.ch));
        check("rec_ts", out_ts, e.ts);
        check("rec_data", 64'(out_data), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input logic [63:0] n);
    for (int k = 0; k < 200 && ecnt != n; k++) tick();
    check("wait_edge", ecnt, n);
  endtask

  task automatic fire(input logic [3:0] m,
                      input logic [31:0] dat,
                      input bit push);
    rec_t r;
    mon_valid = m;
    mon_ready = m;
    mon_data  = dat;
    if (push)
      for (int i = 0; i < 4; i++)
        if (m[i]) begin
          r.ch = 2'(i);
          r.ts = ecnt;
          r.d  = dat[i*8 +: 8];
          q.push_back(r);
        end
    tick();
    mon_valid = '0;
    mon_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mon_valid = '0;
    mon_ready = '0;
    mon_data = '0;
    clr = 1'b0;
    en = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_chan", 64'(out_chan), 64'd0);
    check("rst_ts", out_ts, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    q.delete();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    // single capture and one-cycle latency
    do_reset();
    out_ready = 1'b1;
    wait_edge(64'd5);
    check("t1_idle", 64'(out_valid), 64'd0);
    fire(4'b0010, 32'h0000A500, 1'b1);
    check("t1_lat", 64'(out_valid), 64'd1);
    repeat (3) tick();
    check("t1_q", 64'(q.size()), 64'd0);

    // all channels at one edge drain back to back
    do_reset();
    out_ready = 1'b1;
    wait_edge(64'd10);
    fire(4'b1111, 32'h13121110, 1'b1);
    repeat (4) tick();
    check("t2_q", 64'(q.size()), 64'd0);
    check("t2_idle", 64'(out_valid), 64'd0);

    // overflow, stall stability, clear
    do_reset();
    out_ready = 1'b0;
    wait_edge(64'd3);
    for (int k = 0; k < 10; k++)
      fire(4'b0100, 32'(8'h20 + 8'(k)) << 16, k < 8);
    check("t3_ovf", 64'(ovf), 64'h4);
    check("t3_drop", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 4; k++) begin
      mon_valid = 4'($urandom);
      mon_ready = '0;
      mon_data  = $urandom;
      tick();
      check("t4_valid", 64'(out_valid), 64'd1);
      check("t4_chan", 64'(out_chan), 64'(q[0].ch));
      check("t4_ts", out_ts, q[0].ts);
      check("t4_data", 64'(out_data), 64'(q[0].d));
    end
    mon_valid = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_clr_ovf", 64'(ovf), 64'd0);
    check("t3_clr_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (10) tick();
    check("t3_q", 64'(q.size()), 64'd0);

    // full FIFO: pop and capture on the same edge
    do_reset();
    out_ready = 1'b0;
    wait_edge(64'd2);
    for (int k = 0; k < 8; k++)
      fire(4'b0001, 32'(8'h40 + 8'(k)), 1'b1);
    out_ready = 1'b1;
    fire(4'b0001, 32'h48, 1'b1);
    out_ready = 1'b0;
    check("t5_ovf", 64'(ovf), 64'd0);
    check("t5_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (8) tick();
    check("t5_q", 64'(q.size()), 64'd0);
    check("t5_occ", 64'(out_valid), 64'd0);

    // reset mid-drain discards everything
    do_reset();
    out_ready = 1'b0;
    wait_edge(64'd1);
    for (int k = 0; k < 5; k++)
      fire(4'b0010, 32'(8'h60 + 8'(k)) << 8, 1'b1);
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ts", out_ts, 64'd0);
    q.delete();
    tick();
    check("t6_held", 64'(out_valid), 64'd0);
    rst = 1'b1;
    fire(4'b1000, 32'h77000000, 1'b1);
    check("t6_new", 64'(out_valid), 64'd1);
    repeat (3) tick();
    check("t6_q", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
